// File: rtl/width_cast_serializer.sv
// ---------------------------------------------------------------------------
// width_cast_serializer
//
// Purpose: narrows one IN_W-bit word into N = IN_W/OUT_W chunks of OUT_W bits
//          and streams them out one chunk per accepted beat, with valid/ready
//          handshakes on both sides. A new word can be loaded on the same
//          edge that the last chunk of the previous word leaves, so sustained
//          throughput is one chunk per cycle.
//
// Build option: define WIDTH_CAST_SERIALIZER_MSB_FIRST_EN to emit the most
//               significant chunk first. The default build emits LSB-first.
//               Handshake and timing are identical in both builds.
//
// Parameters:
//   IN_W       input word width (must be an integer multiple of OUT_W)
//   OUT_W      output chunk width
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   in_valid   upstream word present
//   in_ready   block accepts a word this cycle (combinational)
//   in_data    word to narrow
//   out_valid  chunk present
//   out_ready  downstream accepts chunk
//   out_data   current chunk
//   out_last   current chunk is the final beat of its word
//   busy       a word is held (same as out_valid)
// ---------------------------------------------------------------------------
module width_cast_serializer #(
   parameter int IN_W  = 32,
   parameter int OUT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_last,
   output logic             busy
);

   localparam int N  = IN_W / OUT_W;
   // A single-beat word still needs a 1-bit counter so the port widths stay legal.
   localparam int BW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [BW-1:0]    beat_q,  beat_d;
   logic [IN_W-1:0]  hold_q,  hold_d;

   logic last_beat;
   logic in_xfer;
   logic out_xfer;

   assign last_beat = (beat_q == BW'(N - 1));

   // Ready when empty, or when the final chunk is leaving this very cycle,
   // which lets the next word replace it without a bubble.
   assign in_ready  = (state_q == IDLE) |
                      ((state_q == SEND) & out_ready & last_beat);
   assign out_valid = (state_q == SEND);
   assign busy      = out_valid;
   assign out_last  = out_valid & last_beat;

   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = out_valid & out_ready;

   // Chunk select written as a compare-and-pick mux so every slice index
   // is a constant; beat never exceeds N-1, so exactly one arm matches.
   always_comb begin
      out_data = '0;
      for (int i = 0; i < N; i++) begin
         if (beat_q == BW'(i)) begin
`ifdef WIDTH_CAST_SERIALIZER_MSB_FIRST_EN
            out_data = hold_q[(N-1-i)*OUT_W +: OUT_W];
`else
            out_data = hold_q[i*OUT_W +: OUT_W];
`endif
         end
      end
   end

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      hold_d  = hold_q;
      // A load wins over everything: it can only coincide with an output
      // transfer when that transfer is the last beat of the held word.
      if (in_xfer) begin
         hold_d  = in_data;
         beat_d  = '0;
         state_d = SEND;
      end else if (out_xfer) begin
         if (last_beat) begin
            state_d = IDLE;
            beat_d  = '0;
         end else begin
            beat_d  = beat_q + BW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         beat_q  <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         hold_q  <= hold_d;
      end
   end

endmodule

// File: tb/tb_width_cast_serializer.sv
// ---------------------------------------------------------------------------
// tb_width_cast_serializer
//
// Directed bench for width_cast_serializer (IN_W=32, OUT_W=4). A queue-based
// reference model tracks the chunks still owed downstream; a compare process
// checks every output against it on each falling edge. Directed scenarios
// add hand-computed chunk sequences and timing expectations.
// ---------------------------------------------------------------------------
module tb_width_cast_serializer;

   localparam int IN_W  = 32;
   localparam int OUT_W = 4;
   localparam int N     = IN_W / OUT_W;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [IN_W-1:0]  in_data = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [OUT_W-1:0] out_data;
   logic             out_last;
   logic             busy;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   bit chk_en = 1'b0;

   logic [OUT_W-1:0] mq[$];     // model: chunks still to be delivered
   logic [OUT_W-1:0] log_d[$];  // observed transferred chunks
   logic             log_l[$];
   int               log_c[$];

   width_cast_serializer #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a word becomes N chunks in emission order; the block
   // can take a word when nothing is owed, or when the single owed chunk is
   // being taken this cycle.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
      end else begin
         bit m_rdy, ox, ix;
         logic [IN_W-1:0] w;
         cyc++;
         m_rdy = (mq.size() == 0) || (mq.size() == 1 && out_ready);
         ox    = (mq.size() > 0) && out_ready;
         ix    = in_valid && m_rdy;
         w     = in_data;
         if (ox) void'(mq.pop_front());
         if (ix) begin
            for (int k = 0; k < N; k++) begin
`ifdef WIDTH_CAST_SERIALIZER_MSB_FIRST_EN
               mq.push_back(OUT_W'((w >> ((N-1-k)*OUT_W)) & ((1 << OUT_W) - 1)));
`else
               mq.push_back(OUT_W'((w >> (k*OUT_W)) & ((1 << OUT_W) - 1)));
`endif
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         bit ev;
         ev = (mq.size() > 0);
         chk("out_valid", 32'(out_valid), 32'(ev));
         chk("busy", 32'(busy), 32'(ev));
         chk("in_ready", 32'(in_ready),
             32'((mq.size() == 0) || (mq.size() == 1 && out_ready)));
         if (ev) begin
            chk("out_data", 32'(out_data), 32'(mq[0]));
            chk("out_last", 32'(out_last), 32'(mq.size() == 1));
         end else begin
            chk("out_last_idle", 32'(out_last), 32'd0);
         end
         if (rst_n && out_valid && out_ready) begin
            log_d.push_back(out_data);
            log_l.push_back(out_last);
            log_c.push_back(cyc);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present a word until accepted; returns the number of falling edges
   // observed before acceptance (bounded).
   task automatic put(input logic [IN_W-1:0] w, output int waits);
      bit acc;
      acc      = 1'b0;
      waits    = 0;
      in_valid = 1'b1;
      in_data  = w;
      while (!acc && waits < 200) begin
         @(negedge clk);
         waits++;
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      if (!acc) chk("put_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic clear_log();
      log_d.delete();
      log_l.delete();
      log_c.delete();
   endtask

   task automatic check_log8(input string name, input int e[8]);
      chk({name, "_count"}, 32'(log_d.size()), 32'd8);
      if (log_d.size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            chk({name, "_chunk"}, 32'(log_d[i]), 32'(e[i]));
            chk({name, "_last"}, 32'(log_l[i]), 32'(i == 7));
         end
      end
   endtask

   initial begin
      int w;
      int e[8];
      int eb[8];
      logic [OUT_W-1:0] e_hold;

`ifdef WIDTH_CAST_SERIALIZER_MSB_FIRST_EN
      eb     = '{'hD, 'hE, 'hA, 'hD, 'hB, 'hE, 'hE, 'hF};
      e_hold = 4'hA;
`else
      eb     = '{'hF, 'hE, 'hE, 'hB, 'hD, 'hA, 'hE, 'hD};
      e_hold = 4'hE;
`endif

      // Reset state
      #1 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk_en = 1'b1;
      step(2);
      rst_n = 1'b1;
      step(2);
      chk("post_rst_out_data", 32'(out_data), 32'd0);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Single-bit word, latency one cycle
      out_ready = 1'b1;
      clear_log();
      put(32'h0000_0001, w);
      chk("w1_accept_waits", 32'(w), 32'd1);
      @(negedge clk);
      chk("w1_first_valid", 32'(out_valid), 32'd1);
`ifdef WIDTH_CAST_SERIALIZER_MSB_FIRST_EN
      e = '{0, 0, 0, 0, 0, 0, 0, 1};
`else
      e = '{1, 0, 0, 0, 0, 0, 0, 0};
`endif
      step(10);
      check_log8("w1", e);

      // DEADBEEF chunk order
      clear_log();
      put(32'hDEADBEEF, w);
      step(10);
      check_log8("deadbeef", eb);

      // Backpressure while beat 2 is presented
      clear_log();
      put(32'hDEADBEEF, w);
      step(2);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_hold_data", 32'(out_data), 32'(e_hold));
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_valid", 32'(out_valid), 32'd1);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      step(10);
      check_log8("bp", eb);

      // Back-to-back words, no bubble
      clear_log();
      put(32'h1111_1111, w);
      put(32'h2222_2222, w);
      chk("b2b_second_accept_on_8th", 32'(w), 32'd8);
      step(12);
      chk("b2b_count", 32'(log_d.size()), 32'd16);
      if (log_d.size() == 16) begin
         for (int i = 0; i < 16; i++) begin
            chk("b2b_chunk", 32'(log_d[i]), (i < 8) ? 32'h1 : 32'h2);
            if (i > 0) chk("b2b_no_gap", 32'(log_c[i]), 32'(log_c[i-1] + 1));
         end
      end

      // Reset mid-word after three chunks
      clear_log();
      put(32'hDEADBEEF, w);
      step(3);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      step(2);
      rst_n = 1'b1;
      step(12);
      chk("mid_rst_chunks", 32'(log_d.size()), 32'd3);
      if (log_d.size() == 3)
         for (int i = 0; i < 3; i++) chk("mid_rst_chunk", 32'(log_d[i]), 32'(eb[i]));

      // Mixed stream with a fixed out_ready pattern, checked by the model
      fork
         begin
            logic [15:0] pat;
            pat = 16'b1011_0011_1101_0110;
            for (int i = 0; i < 60; i++) begin
               out_ready = pat[i % 16];
               step(1);
            end
            out_ready = 1'b1;
         end
         begin
            put(32'h0123_4567, w);
            put(32'h89AB_CDEF, w);
            step(3);
            put(32'hF0F0_A5A5, w);
         end
      join
      step(12);
      chk("final_idle", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/width_cast_serializer.md
WIDTH_CAST_SERIALIZER -- requirements
Module: width_cast_serializer

Interface
REQ-001 SHALL have parameter IN_W, default 32, input word width in bits.
REQ-002 SHALL have parameter OUT_W, default 4, output chunk width in bits; IN_W SHALL be an integer multiple of OUT_W; N = IN_W/OUT_W beats per word.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk (input, 1) and rst_n (input, 1).
REQ-004 SHALL have in_valid, input, 1: upstream word present.
REQ-005 SHALL have in_ready, output, 1: block accepts word this cycle.
REQ-006 SHALL have in_data, input, IN_W: word to narrow.
REQ-007 SHALL have out_valid, output, 1: chunk present.
REQ-008 SHALL have out_ready, input, 1: downstream accepts chunk.
REQ-009 SHALL have out_data, output, OUT_W: current chunk.
REQ-010 SHALL have out_last, output, 1: current chunk is beat N-1 of its word.
REQ-011 SHALL have busy, output, 1: a word is held.

Function
REQ-012 SHALL implement two states: IDLE (no word held) and SEND (word held, chunks pending).
REQ-013 SHALL transfer input when in_valid & in_ready at a rising clk edge; output transfers when out_valid & out_ready.
REQ-014 SHALL drive in_ready = (state==IDLE) | (state==SEND & out_ready & beat==N-1), combinationally.
REQ-015 SHALL, on input transfer, capture in_data into a holding register, set beat = 0 and enter SEND; the first chunk SHALL appear at out_data the cycle after acceptance (latency 1).
REQ-016 SHALL drive out_valid = (state==SEND); busy SHALL equal out_valid.
REQ-017 SHALL drive out_data = holding[beat*OUT_W +: OUT_W] (LSB-first order, default build).
REQ-018 SHALL drive out_last = out_valid & (beat==N-1).
REQ-019 SHALL hold out_data, out_last and beat stable while out_valid & !out_ready.
REQ-020 SHALL, on output transfer with beat<N-1, increment beat by 1.
REQ-021 SHALL, on output transfer with beat==N-1 and no input transfer, return to IDLE.
REQ-022 SHALL, on simultaneous last-beat output transfer and input transfer, load the new word, set beat=0 and remain in SEND (no bubble; sustained throughput one chunk per cycle).
REQ-023 SHALL size beat counter to $clog2(N) bits (minimum 1); beat SHALL never exceed N-1.
REQ-024 SHALL ignore in_data and in_valid while in_ready is low; no word SHALL be dropped or duplicated.

Reset
REQ-025 SHALL, while rst_n is low, force state=IDLE, beat=0, holding register=0, asynchronously.
REQ-026 SHALL present out_valid=0, out_last=0, busy=0, out_data=0, in_ready=1 during and after reset until the first input transfer.
REQ-027 SHALL discard any partially sent word when reset asserts mid-operation; no remaining chunks SHALL be emitted after release.

Configuration
REQ-028 SHALL honour macro WIDTH_CAST_SERIALIZER_MSB_FIRST_EN.
REQ-029 SHALL, with the macro defined, emit chunks MSB-first: out_data = holding[(N-1-beat)*OUT_W +: OUT_W].
REQ-030 SHALL, without the macro, emit LSB-first per REQ-017; all handshake and timing behaviour SHALL be identical in both builds.

Verification
REQ-031 Default build, in_data=32'h0000_0001, out_ready=1 -> out_data 1,0,0,0,0,0,0,0 on 8 consecutive cycles starting one cycle after acceptance; out_last only on 8th.
REQ-032 in_data=32'hDEADBEEF, out_ready=1 -> default build F,E,E,B,D,A,E,D; MSB_FIRST_EN build D,E,A,D,B,E,E,F.
REQ-033 Backpressure: out_ready=0 for 3 cycles while beat=2 of 32'hDEADBEEF -> out_data holds E for 3 cycles, in_ready=0, then sequence resumes with B.
REQ-034 Back-to-back: in_valid=1 with words 32'h1111_1111 then 32'h2222_2222, out_ready=1 -> 16 chunks on 16 consecutive cycles, in_ready=1 on cycle of 8th chunk, no gap.
REQ-035 Reset mid-word: rst_n low after 3rd chunk of 32'hDEADBEEF -> out_valid=0 immediately, busy=0, in_ready=1; after release no chunks until new in_valid.
